// File: rtl/reg_bank_sb.sv
// Parametrised register file with write-through bypass, RAW pending scoreboard
// and a sequential soft-clear engine that zeroes one register per cycle.
module reg_bank_sb #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     r_addr_a,
  input  logic [AW-1:0]     r_addr_b,
  output logic [DATA_W-1:0] r_data_a,
  output logic [DATA_W-1:0] r_data_b,
  output logic              busy_a,
  output logic              busy_b,
  input  logic [AW-1:0]     w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              wr_en,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              ready
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW:0]   NREGS_W  = (AW + 1)'(NREGS);

  state_t            r_state;
  state_t            w_next_state;
  logic [AW-1:0]     r_ptr;
  logic [DATA_W-1:0] r_regs [1:NREGS-1];
  logic [NREGS-1:1]  r_pend;
  logic              w_ready;
  logic              w_wr_ok;

  // Out-of-range and R0 writes are dropped, so they never feed the bypass either.
  assign w_wr_ok = wr_en && w_ready && (w_addr != '0) && ({1'b0, w_addr} < NREGS_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE && clr_req)
        r_ptr <= AW'(1);
      else if (r_state == CLEAR)
        r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + AW'(1);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (clr_req) w_next_state = CLEAR;
      CLEAR:   if (r_ptr == LAST_IDX) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ready  = (r_state == IDLE);
    clr_busy = (r_state == CLEAR);
    ready    = w_ready;
  end

  // An issue and a writeback to the same register in one cycle leave it pending:
  // the newly issued producer has not written back yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREGS; i++) begin
        r_regs[i] <= '0;
        r_pend[i] <= 1'b0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (r_state == CLEAR) begin
          if (r_ptr == AW'(i)) begin
            r_regs[i] <= '0;
            r_pend[i] <= 1'b0;
          end
        end else begin
          if (wr_en && w_addr == AW'(i))
            r_regs[i] <= w_data;
          if (iss_en && iss_rd == AW'(i))
            r_pend[i] <= 1'b1;
          else if (wr_en && w_addr == AW'(i))
            r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    r_data_a = '0;
    busy_a   = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (r_addr_a == AW'(i)) begin
        r_data_a = r_regs[i];
        busy_a   = r_pend[i];
      end
    end
    if (w_wr_ok && w_addr == r_addr_a) begin
      r_data_a = w_data;
      busy_a   = 1'b0;
    end
  end

  always_comb begin
    r_data_b = '0;
    busy_b   = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (r_addr_b == AW'(i)) begin
        r_data_b = r_regs[i];
        busy_b   = r_pend[i];
      end
    end
    if (w_wr_ok && w_addr == r_addr_b) begin
      r_data_b = w_data;
      busy_b   = 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed self-checking bench for reg_bank_sb: default instance plus two
// parameter variants sharing one stimulus bus.
module tb_reg_bank_sb;

  logic        clk;
  logic        rst;
  logic [4:0]  r_addr_a;
  logic [4:0]  r_addr_b;
  logic [4:0]  w_addr;
  logic [63:0] w_data;
  logic        wr_en;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic        clr_req;

  logic [31:0] d0a, d0b;
  logic        b0a, b0b, cb0, rdy0;
  logic [63:0] d1a, d1b;
  logic        b1a, b1b, cb1, rdy1;
  logic [31:0] d2a, d2b;
  logic        b2a, b2b, cb2, rdy2;

  int errors = 0;
  int checks = 0;

  reg_bank_sb #(.DATA_W(32), .NREGS(16), .AW(5)) u0 (
    .clk(clk), .rst(rst),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .r_data_a(d0a), .r_data_b(d0b), .busy_a(b0a), .busy_b(b0b),
    .w_addr(w_addr), .w_data(w_data[31:0]), .wr_en(wr_en),
    .iss_en(iss_en), .iss_rd(iss_rd), .clr_req(clr_req),
    .clr_busy(cb0), .ready(rdy0)
  );

  reg_bank_sb #(.DATA_W(64), .NREGS(32), .AW(5)) u1 (
    .clk(clk), .rst(rst),
    .r_addr_a(r_addr_a), .r_addr_b(r_addr_b),
    .r_data_a(d1a), .r_data_b(d1b), .busy_a(b1a), .busy_b(b1b),
    .w_addr(w_addr), .w_data(w_data), .wr_en(wr_en),
    .iss_en(iss_en), .iss_rd(iss_rd), .clr_req(clr_req),
    .clr_busy(cb1), .ready(rdy1)
  );

  reg_bank_sb #(.DATA_W(32), .NREGS(10), .AW(4)) u2 (
    .clk(clk), .rst(rst),
    .r_addr_a(r_addr_a[3:0]), .r_addr_b(r_addr_b[3:0]),
    .r_data_a(d2a), .r_data_b(d2b), .busy_a(b2a), .busy_b(b2b),
    .w_addr(w_addr[3:0]), .w_data(w_data[31:0]), .wr_en(wr_en),
    .iss_en(iss_en), .iss_rd(iss_rd[3:0]), .clr_req(clr_req),
    .clr_busy(cb2), .ready(rdy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en   = 1'b0;
    iss_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    r_addr_a = 5'd3; r_addr_b = 5'd7;
    w_addr = 5'd0; w_data = 64'd0; iss_rd = 5'd0;
    #2;
    checks++;
    if (d0a !== 32'd0 || d0b !== 32'd0 || b0a !== 1'b0 || b0b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_read got a=%h b=%h busy=%b%b exp 0", d0a, d0b, b0a, b0b);
    end
    checks++;
    if (cb0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_fsm got clr_busy=%b ready=%b exp 0/1", cb0, rdy0);
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; w_addr = 5'd3; w_data = 64'hAA;
    tick();
    wr_en = 1'b0; r_addr_a = 5'd3;
    @(negedge clk);
    checks++;
    if (d0a !== 32'hAA || b0a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_read_r3 got %h busy=%b exp 000000aa busy=0", d0a, b0a);
    end
    tick();
    wr_en = 1'b1; w_addr = 5'd0; w_data = 64'h55; r_addr_a = 5'd0;
    @(negedge clk);
    checks++;
    if (d0a !== 32'd0) begin
      errors++;
      $display("[TB] FAIL r0_no_bypass got %h exp 0", d0a);
    end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (d0a !== 32'd0) begin
      errors++;
      $display("[TB] FAIL r0_write got %h exp 0", d0a);
    end
    tick();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; w_addr = 5'd5; w_data = 64'h1234; r_addr_b = 5'd5;
    @(negedge clk);
    checks++;
    if (d0b !== 32'h1234 || b0b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass_same_cycle got %h busy=%b exp 00001234 busy=0", d0b, b0b);
    end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (d0b !== 32'h1234) begin
      errors++;
      $display("[TB] FAIL bypass_stored got %h exp 00001234", d0b);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_rd = 5'd7; r_addr_a = 5'd7;
    tick();
    iss_en = 1'b0;
    @(negedge clk);
    checks++;
    if (b0a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL issue_sets_busy got %b exp 1", b0a);
    end
    tick();
    wr_en = 1'b1; w_addr = 5'd7; w_data = 64'h77;
    @(negedge clk);
    checks++;
    if (b0a !== 1'b0 || d0a !== 32'h77) begin
      errors++;
      $display("[TB] FAIL wb_bypass_busy got busy=%b data=%h exp busy=0 data=00000077", b0a, d0a);
    end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (b0a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wb_clears_busy got %b exp 0", b0a);
    end
    tick();
    iss_en = 1'b1; iss_rd = 5'd7; wr_en = 1'b1; w_addr = 5'd7; w_data = 64'h88;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (b0a !== 1'b1 || d0a !== 32'h88) begin
      errors++;
      $display("[TB] FAIL set_wins got busy=%b data=%h exp busy=1 data=00000088", b0a, d0a);
    end
    tick();
    iss_en = 1'b1; iss_rd = 5'd0; r_addr_b = 5'd0;
    tick();
    iss_en = 1'b0;
    @(negedge clk);
    checks++;
    if (b0b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r0_never_pending got %b exp 0", b0b);
    end
    tick();
  endtask

  task automatic test_soft_clear();
    int  cnt;
    logic done;
    for (int i = 1; i < 16; i++) begin
      wr_en = 1'b1; w_addr = 5'(i); w_data = 64'h100 + 64'(i);
      tick();
    end
    wr_en = 1'b0;
    iss_en = 1'b1; iss_rd = 5'd9;
    tick();
    // clear starts in the same cycle as a write to R2
    iss_en = 1'b0; clr_req = 1'b1; wr_en = 1'b1; w_addr = 5'd2; w_data = 64'hBEEF;
    tick();
    idle_inputs();
    r_addr_a = 5'd15; r_addr_b = 5'd2;
    cnt = 0; done = 1'b0;
    while (!done && cnt < 40) begin
      if (cnt == 3) begin
        wr_en = 1'b1; w_addr = 5'd1; w_data = 64'hDEAD; r_addr_b = 5'd1;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (cb0 !== 1'b1) begin
        done = 1'b1;
      end else begin
        if (cnt == 0) begin
          checks++;
          if (d0a !== 32'h10F || d0b !== 32'hBEEF || rdy0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clear_partial got r15=%h r2=%h ready=%b exp 0000010f 0000beef 0", d0a, d0b, rdy0);
          end
        end
        if (cnt == 3) begin
          checks++;
          if (d0b !== 32'd0) begin
            errors++;
            $display("[TB] FAIL clear_no_bypass got %h exp 0", d0b);
          end
        end
        cnt++;
        tick();
      end
    end
    wr_en = 1'b0;
    checks++;
    if (cnt !== 15) begin
      errors++;
      $display("[TB] FAIL clear_busy_cycles got %0d exp 15", cnt);
    end
    tick();
    for (int i = 1; i < 16; i++) begin
      r_addr_a = 5'(i);
      #1;
      checks++;
      if (d0a !== 32'd0 || b0a !== 1'b0) begin
        errors++;
        $display("[TB] FAIL cleared_r%0d got %h busy=%b exp 0 busy=0", i, d0a, b0a);
      end
    end
    checks++;
    if (rdy0 !== 1'b1 || cb0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_done got ready=%b clr_busy=%b exp 1/0", rdy0, cb0);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    wr_en = 1'b1; w_addr = 5'd15; w_data = 64'h5A;
    tick();
    wr_en = 1'b0; iss_en = 1'b1; iss_rd = 5'd14;
    tick();
    iss_en = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    r_addr_a = 5'd15; r_addr_b = 5'd14;
    #2;
    checks++;
    if (cb0 !== 1'b1 || d0a !== 32'h5A || b0b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_state got clr_busy=%b r15=%h busy14=%b exp 1 0000005a 1", cb0, d0a, b0b);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (cb0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear_fsm got clr_busy=%b ready=%b exp 0/1", cb0, rdy0);
    end
    checks++;
    if (d0a !== 32'd0 || b0b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_clear_data got r15=%h busy14=%b exp 0/0", d0a, b0b);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (d0a !== 32'd0 || cb0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL after_release got r15=%h clr_busy=%b exp 0/0", d0a, cb0);
    end
    tick();
  endtask

  task automatic test_param_sweep();
    wr_en = 1'b1; w_addr = 5'd31; w_data = 64'hDEADBEEF_CAFEF00D;
    tick();
    w_addr = 5'd9; w_data = 64'h99;
    tick();
    wr_en = 1'b0; r_addr_a = 5'd31; r_addr_b = 5'd9;
    @(negedge clk);
    checks++;
    if (d1a !== 64'hDEADBEEF_CAFEF00D) begin
      errors++;
      $display("[TB] FAIL w64_top_r31 got %h exp deadbeefcafef00d", d1a);
    end
    checks++;
    if (d2b !== 32'h99) begin
      errors++;
      $display("[TB] FAIL n10_top_r9 got %h exp 00000099", d2b);
    end
    tick();
    wr_en = 1'b1; w_addr = 5'd12; w_data = 64'h77; r_addr_a = 5'd12;
    @(negedge clk);
    checks++;
    if (d2a !== 32'd0 || b2a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL n10_oob_bypass got %h busy=%b exp 0/0", d2a, b2a);
    end
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (d2a !== 32'd0) begin
      errors++;
      $display("[TB] FAIL n10_oob_write got %h exp 0", d2a);
    end
    checks++;
    if (d1a !== 64'h77) begin
      errors++;
      $display("[TB] FAIL w64_r12 got %h exp 0000000000000077", d1a);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_soft_clear();
    test_reset_mid_clear();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_sb.md
Name: reg_bank_sb

Overview:
- Parametrised successor register file for the pipelined Mini RISC core: configurable data width and register count, two asynchronous read ports, one synchronous write port with write-through bypass.
- Adds a per-register pending scoreboard for RAW hazard detection, set at issue and cleared at writeback.
- Adds a sequential soft-clear engine that zeroes the file one register per cycle.
- Sits between decode (read/issue) and writeback.

Parameters:
- DATA_W, 32, register width in bits
- NREGS, 16, number of architectural registers (2..64); R0 hardwired to zero
- AW, 5, address width; must satisfy 2^AW >= NREGS

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- r_addr_a  in  AW  read port A address
- r_addr_b  in  AW  read port B address
- r_data_a  out  DATA_W  read data A
- r_data_b  out  DATA_W  read data B
- busy_a  out  1  register at r_addr_a has a pending write
- busy_b  out  1  register at r_addr_b has a pending write
- w_addr  in  AW  write address
- w_data  in  DATA_W  write data
- wr_en  in  1  write strobe; also clears the pending bit of w_addr
- iss_en  in  1  issue strobe; sets the pending bit of iss_rd
- iss_rd  in  AW  destination register of the issued instruction
- clr_req  in  1  single-cycle pulse starting a soft clear
- clr_busy  out  1  soft clear in progress
- ready  out  1  file accepts writes and issues (= !clr_busy)

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers 0; all pending bits 0
  - clear FSM in IDLE; clr_busy=0, ready=1
  - outputs settle combinationally (r_data_*=0, busy_*=0)
- Reads are combinational:
  - address 0 or address >= NREGS -> data 0, busy 0
  - otherwise the file contents
  - bypass: if wr_en && ready && w_addr==r_addr_x && w_addr!=0 && w_addr<NREGS, r_data_x = w_data in the same cycle
- busy_x = pending[r_addr_x] & ~(wr_en & ready & w_addr==r_addr_x). The bypassed value is final, so there is no stall.
- Write: on posedge, if wr_en && ready && w_addr!=0 && w_addr<NREGS, the file is updated. Otherwise the write is dropped silently.
- Scoreboard, per register i != 0, on posedge with ready=1:
  - set if iss_en && iss_rd==i
  - clear if wr_en && w_addr==i
  - simultaneous set and clear of the same i: set wins (new producer issued)
  - pending[0] is always 0; iss_rd >= NREGS is ignored
- Clear FSM, states IDLE, CLEAR:
  - IDLE: clr_req=1 -> CLEAR, ptr=1, clr_busy=1 from the next cycle.
  - CLEAR: each cycle writes 0 to register ptr and clears pending[ptr], then ptr++. When ptr==NREGS-1 is written -> IDLE; clr_busy drops the following cycle.
  - Total clr_busy high time is NREGS-1 cycles.
  - During CLEAR: wr_en and iss_en are ignored (ready=0); bypass is disabled; reads return current contents (partially cleared).
  - clr_req during CLEAR is ignored (no restart).
  - clr_req in the same cycle as wr_en/iss_en in IDLE: the write and issue take effect in that cycle; clear starts the next cycle and overwrites the result.
- Reset asserted mid-CLEAR: immediate return to IDLE, all state zeroed.
- No arithmetic beyond the AW-bit ptr increment; ptr never wraps because the FSM exits at NREGS-1.

Test Plan:
- Reset, then write R3=0x0000_00AA, then read A=3 next cycle -> r_data_a=0xAA, busy_a=0; write to R0 = 0x55 -> read R0 = 0.
- Bypass: wr_en w_addr=5 w_data=0x1234 with r_addr_b=5 in the same cycle -> r_data_b=0x1234 that cycle, busy_b=0.
- Scoreboard:
  - iss_en iss_rd=7 -> next cycle busy_a=1 for r_addr_a=7.
  - wr_en w_addr=7 -> busy_a=0 that cycle (bypass) and after.
  - iss_en rd=7 together with wr_en w_addr=7 -> pending stays 1.
- Soft clear with NREGS=16, R1..R15 preloaded non-zero:
  - pulse clr_req -> clr_busy high exactly 15 cycles; all reads 0 afterwards; all busy 0.
  - wr_en during the clear -> dropped.
- Reset mid-clear: drop rst at clear cycle 4 -> clr_busy=0 and ready=1 immediately; all registers 0 after release.
- Parameter sweep DATA_W=64, NREGS=32, AW=5 and NREGS=10, AW=4: write/read R31 (or R9) at the top address; address 12 with NREGS=10 -> read 0, write ignored.
